// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register sitting directly after the register file.
//   Latches the rs/rt operands, immediate, destination and control bundle
//   for EX. It also provides:
//     - WB->ID write-through bypass at capture time (register 0 reads as 0)
//     - load-use hazard detection with single-bubble insertion
//     - flush (branch/jump redirect) with priority over everything but reset
//     - valid/ready backpressure in both directions
//
//   Optional feature macro: ID_EX_PERF_CNT_EN
//     defined     -> stall_cnt counts stall cycles (saturating, cleared by rst)
//     not defined -> stall_cnt tied to 0, no counter logic
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] dst,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_dst,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              hazard,
  output logic [31:0]       stall_cnt
);

  // Control bundle bit positions used by this stage.
  localparam int CTRL_MEM_READ = 1;

  // What the stage register does on the next clock edge (reset handled apart).
  typedef enum logic [2:0] {
    ACT_HOLD,    // keep everything (EX stalled, or idle)
    ACT_FLUSH,   // kill contents, drop the input
    ACT_BUBBLE,  // load moves on, dependent instruction waits one cycle
    ACT_LOAD,    // capture the decode-side instruction
    ACT_DRAIN    // EX took the instruction and nothing new arrived
  } act_e;

  act_e              act;
  logic [DATA_W-1:0] rs_operand;
  logic [DATA_W-1:0] rt_operand;

  // Operand select: register 0 is hardwired zero, then a same-cycle WB write
  // to the source register wins over the (stale) register-file read.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_value
  );
    if (src == '0)
      return '0;
    if (wb_we && (wb_addr == src))
      return wb_value;
    return rf_data;
  endfunction

  // Hazard detection, upstream handshake and next-action priority decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hazard   = 1'b0;
    in_ready = 1'b0;
    act      = ACT_HOLD;

    hazard = in_valid & out_valid & out_ctrl[CTRL_MEM_READ] &
             (out_dst != '0) & ((out_dst == rs) | (out_dst == rt));

    in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);

    if (flush)
      act = ACT_FLUSH;
    else if (hazard)
      act = out_ready ? ACT_BUBBLE : ACT_HOLD;
    else if (in_valid && in_ready)
      act = ACT_LOAD;
    else if (out_valid && out_ready)
      act = ACT_DRAIN;
  end

  // Bypassed operands presented to the stage register.
  always_comb begin
    rs_operand = pick_operand(rs, read_data1, wb_reg_write, wb_dst, wb_data);
    rt_operand = pick_operand(rt, read_data2, wb_reg_write, wb_dst, wb_data);
  end

  // Stage register: synchronous reset, then the decoded action.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the payload fields are reset too, not just out_valid, because
      // EX and debug logic observe them directly and must see zeros after reset.
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_dst     <= '0;
      out_imm     <= '0;
      out_ctrl    <= '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          out_valid   <= 1'b1;
          out_rs_data <= rs_operand;
          out_rt_data <= rt_operand;
          out_rs      <= rs;
          out_rt      <= rt;
          out_dst     <= dst;
          out_imm     <= imm;
          out_ctrl    <= ctrl;
        end
        ACT_FLUSH, ACT_BUBBLE, ACT_DRAIN: begin
          // Payload is left in place; a zero control bundle makes it inert.
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end
        default: begin
          // ACT_HOLD: everything keeps its value.
        end
      endcase
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic stall_cycle;

  // A cycle is a stall when decode is blocked by a load-use hazard or by EX.
  always_comb begin
    stall_cycle = hazard | (in_valid & out_valid & ~out_ready);
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_cycle && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed, table-driven bench for id_ex_stage plus hand-written sequences
//   for reset, mid-stream reset and multi-cycle backpressure.
//   Build with +define+ID_EX_PERF_CNT_EN to expect a live stall counter.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs, rt, dst;
  logic [31:0] read_data1, read_data2, imm;
  logic [9:0]  ctrl;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [9:0]  out_ctrl;
  logic        hazard;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [31:0] EXP_HOLD_STALLS = 32'd3;
`else
  localparam logic [31:0] EXP_HOLD_STALLS = 32'd0;
`endif

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rs           (rs),
    .rt           (rt),
    .dst          (dst),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .imm          (imm),
    .ctrl         (ctrl),
    .wb_reg_write (wb_reg_write),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs_data  (out_rs_data),
    .out_rt_data  (out_rt_data),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_dst      (out_dst),
    .out_imm      (out_imm),
    .out_ctrl     (out_ctrl),
    .hazard       (hazard),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush, in_valid, out_ready;
    logic [4:0]  rs, rt, dst;
    logic [31:0] rd1, rd2, imm;
    logic [9:0]  ctrl;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        e_ready, e_hazard, e_valid;
    logic [31:0] e_rs_d, e_rt_d;
    logic [9:0]  e_ctrl;
    logic [4:0]  e_dst;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic ordy,
    input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
    input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im, input logic [9:0] c,
    input logic we, input logic [4:0] wd, input logic [31:0] wv,
    input logic erdy, input logic ehaz, input logic eval,
    input logic [31:0] ers, input logic [31:0] ert, input logic [9:0] ec, input logic [4:0] ed
  );
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.out_ready = ordy;
    v.rs = s1; v.rt = s2; v.dst = d;
    v.rd1 = r1; v.rd2 = r2; v.imm = im; v.ctrl = c;
    v.wb_we = we; v.wb_dst = wd; v.wb_data = wv;
    v.e_ready = erdy; v.e_hazard = ehaz; v.e_valid = eval;
    v.e_rs_d = ers; v.e_rt_d = ert; v.e_ctrl = ec; v.e_dst = ed;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    flush        = v.flush;
    in_valid     = v.in_valid;
    out_ready    = v.out_ready;
    rs           = v.rs;
    rt           = v.rt;
    dst          = v.dst;
    read_data1   = v.rd1;
    read_data2   = v.rd2;
    imm          = v.imm;
    ctrl         = v.ctrl;
    wb_reg_write = v.wb_we;
    wb_dst       = v.wb_dst;
    wb_data      = v.wb_data;
  endtask

  // Drive on the falling edge, check combinational outputs, then check the
  // registered outputs 1 time unit after the rising edge.
  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, v.e_ready});
    check($sformatf("v%0d hazard", i), {31'd0, hazard}, {31'd0, v.e_hazard});
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, v.e_valid});
    check($sformatf("v%0d out_rs_data", i), out_rs_data, v.e_rs_d);
    check($sformatf("v%0d out_rt_data", i), out_rt_data, v.e_rt_d);
    check($sformatf("v%0d out_ctrl", i), {22'd0, out_ctrl}, {22'd0, v.e_ctrl});
    check($sformatf("v%0d out_dst", i), {27'd0, out_dst}, {27'd0, v.e_dst});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " out_rs_data"}, out_rs_data, 32'd0);
    check({tag, " out_rt_data"}, out_rt_data, 32'd0);
    check({tag, " out_rs"}, {27'd0, out_rs}, 32'd0);
    check({tag, " out_rt"}, {27'd0, out_rt}, 32'd0);
    check({tag, " out_dst"}, {27'd0, out_dst}, 32'd0);
    check({tag, " out_imm"}, out_imm, 32'd0);
    check({tag, " out_ctrl"}, {22'd0, out_ctrl}, 32'd0);
    check({tag, " stall_cnt"}, stall_cnt, 32'd0);
  endtask

  initial begin
    //            fl iv or  rs  rt  dst  rd1      rd2      imm      ctrl     we wd  wdata     rdy hz vl  e_rs_d   e_rt_d   e_ctrl   e_dst
    // Basic capture
    vecs[0]  = mk(0, 1, 1,  3,  4,  6,  32'h11,  32'h22,  32'h100, 10'h001, 0, 0,  32'h0,    1, 0, 1,  32'h11,  32'h22,  10'h001, 6);
    // WB bypass on rs; drain+accept back to back
    vecs[1]  = mk(0, 1, 1,  5,  7,  9,  32'h1,   32'h77,  32'h101, 10'h001, 1, 5,  32'hDEAD, 1, 0, 1,  32'hDEAD, 32'h77, 10'h001, 9);
    // rs = 0 captures 0 even with WB to register 0 and nonzero RF data
    vecs[2]  = mk(0, 1, 1,  0,  5,  10, 32'h55,  32'h66,  32'h102, 10'h001, 1, 0,  32'hBEEF, 1, 0, 1,  32'h0,   32'h66,  10'h001, 10);
    // WB bypass on rt
    vecs[3]  = mk(0, 1, 1,  2,  12, 4,  32'h20,  32'h30,  32'h103, 10'h041, 1, 12, 32'hCAFE, 1, 0, 1,  32'h20,  32'hCAFE, 10'h041, 4);
    // WB address matches but write disabled: no bypass; this is a load to r8
    vecs[4]  = mk(0, 1, 1,  2,  2,  8,  32'h44,  32'h44,  32'h104, 10'h003, 0, 2,  32'h99,   1, 0, 1,  32'h44,  32'h44,  10'h003, 8);
    // Load-use on rs=8 with EX ready: bubble
    vecs[5]  = mk(0, 1, 1,  8,  1,  11, 32'h88,  32'h11,  32'h105, 10'h001, 0, 0,  32'h0,    0, 1, 0,  32'h44,  32'h44,  10'h000, 8);
    // Same instruction held by decode is accepted one cycle later
    vecs[6]  = mk(0, 1, 1,  8,  1,  11, 32'h88,  32'h11,  32'h105, 10'h001, 0, 0,  32'h0,    1, 0, 1,  32'h88,  32'h11,  10'h001, 11);
    // Flush with full stage and valid input: killed, input not captured
    vecs[7]  = mk(1, 1, 1,  4,  4,  12, 32'hF0,  32'hF0,  32'h106, 10'h001, 0, 0,  32'h0,    0, 0, 0,  32'h88,  32'h11,  10'h000, 11);
    vecs[8]  = mk(0, 1, 1,  1,  2,  3,  32'hA1,  32'hA2,  32'h107, 10'h201, 0, 0,  32'h0,    1, 0, 1,  32'hA1,  32'hA2,  10'h201, 3);
    // Drain with no new input
    vecs[9]  = mk(0, 0, 1,  1,  2,  3,  32'hA1,  32'hA2,  32'h107, 10'h201, 0, 0,  32'h0,    1, 0, 0,  32'hA1,  32'hA2,  10'h000, 3);
    // Load to r7
    vecs[10] = mk(0, 1, 1,  1,  1,  7,  32'h5,   32'h5,   32'h108, 10'h002, 0, 0,  32'h0,    1, 0, 1,  32'h5,   32'h5,   10'h002, 7);
    // Load-use on rt=7 with EX stalled: hold
    vecs[11] = mk(0, 1, 0,  9,  7,  13, 32'h90,  32'h70,  32'h109, 10'h001, 0, 0,  32'h0,    0, 1, 1,  32'h5,   32'h5,   10'h002, 7);
    // EX ready: bubble
    vecs[12] = mk(0, 1, 1,  9,  7,  13, 32'h90,  32'h70,  32'h109, 10'h001, 0, 0,  32'h0,    0, 1, 0,  32'h5,   32'h5,   10'h000, 7);
    // Dependent instruction accepted
    vecs[13] = mk(0, 1, 1,  9,  7,  13, 32'h90,  32'h70,  32'h109, 10'h001, 0, 0,  32'h0,    1, 0, 1,  32'h90,  32'h70,  10'h001, 13);
    // Load writing r0
    vecs[14] = mk(0, 1, 1,  3,  3,  0,  32'h1,   32'h1,   32'h10A, 10'h002, 0, 0,  32'h0,    1, 0, 1,  32'h1,   32'h1,   10'h002, 0);
    // Reading r0 after a load to r0 is not a hazard; operands forced 0
    vecs[15] = mk(0, 1, 1,  0,  0,  14, 32'h12,  32'h12,  32'h10B, 10'h001, 0, 0,  32'h0,    1, 0, 1,  32'h0,   32'h0,   10'h001, 14);

    // Reset for two cycles with an instruction offered: never accepted.
    rst = 1'b1;
    drive(mk(0, 1, 1, 3, 4, 6, 32'h11, 32'h22, 32'h100, 10'h001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rst in_ready 2", {31'd0, in_ready}, 32'd0);
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      apply(i);

    // Reset asserted mid-stream with a valid instruction in the stage.
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 1, 1, 6, 6, 6, 32'h3, 32'h3, 32'h3, 10'h3FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_all_zero("midrst");

    // Capture one instruction, then hold EX off for three cycles.
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 1, 1, 6, 7, 15, 32'h61, 32'h71, 32'h1234, 10'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("hold fill out_valid", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(mk(0, 1, 0, 1, 2, 3, 32'hFFFF, 32'hEEEE, 32'h5555, 10'h3FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check($sformatf("hold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("hold%0d hazard", c), {31'd0, hazard}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold%0d out_rs_data", c), out_rs_data, 32'h61);
      check($sformatf("hold%0d out_rt_data", c), out_rt_data, 32'h71);
      check($sformatf("hold%0d out_rs", c), {27'd0, out_rs}, 32'd6);
      check($sformatf("hold%0d out_rt", c), {27'd0, out_rt}, 32'd7);
      check($sformatf("hold%0d out_dst", c), {27'd0, out_dst}, 32'd15);
      check($sformatf("hold%0d out_imm", c), out_imm, 32'h1234);
      check($sformatf("hold%0d out_ctrl", c), {22'd0, out_ctrl}, 32'h005);
    end
    check("hold stall_cnt", stall_cnt, EXP_HOLD_STALLS);

    // Release EX: held instruction leaves as the new one enters.
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("release out_valid", {31'd0, out_valid}, 32'd1);
    check("release out_rs_data", out_rs_data, 32'hFFFF);
    check("release out_rt_data", out_rt_data, 32'hEEEE);
    check("release out_imm", out_imm, 32'h5555);
    check("release out_ctrl", {22'd0, out_ctrl}, 32'h3FF);
    check("release stall_cnt", stall_cnt, EXP_HOLD_STALLS);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final drain out_valid", {31'd0, out_valid}, 32'd0);
    check("final drain out_ctrl", {22'd0, out_ctrl}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
